ctrl_fsm: RTL and testbench



---
 rtl/defs_pkg.sv | 86 ++++++++
 rtl/brh_cond_eval.sv | 28 ++
 rtl/ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/defs_pkg.sv
// Shared datapath/control types for the multi-cycle CPU controller.
package defs_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_opcode_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

    typedef struct packed {
        logic ROM_read;
        logic IR_load;
        logic PC_write;
        logic AB_load;
        logic ALU_op;
        logic ACC_load;
        logic FLAG_load;
        logic MAR_load;
        logic MDR_load;
        logic MEM_read;
        logic MEM_write;
        logic RF_write;
    } ctrl_sig_t;

    typedef enum logic [4:0] {
        STATE_FETCH     = 5'd0,
        STATE_DECODE    = 5'd1,
        STATE_WB_LI     = 5'd2,
        STATE_EXEC_ADDI = 5'd3,
        STATE_WB_ADDI   = 5'd4,
        STATE_EXEC_LW   = 5'd5,
        STATE_MEM_LW    = 5'd6,
        STATE_WB_LW     = 5'd7,
        STATE_EXEC_SW   = 5'd8,
        STATE_MEM_SW    = 5'd9,
        STATE_EXEC_ALU  = 5'd10,
        STATE_WB_ALU    = 5'd11,
        STATE_EXEC_LINK = 5'd12,
        STATE_EXEC_JMP  = 5'd13,
        STATE_EXEC_JPR  = 5'd14,
        STATE_EXEC_BRH  = 5'd15,
        STATE_TRAP      = 5'b10000
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_LI   = 4'd0,
        OP_ADDI = 4'd1,
        OP_LW   = 4'd2,
        OP_SW   = 4'd3,
        OP_ALU  = 4'd4,
        OP_LINK = 4'd5,
        OP_JMP  = 4'd6,
        OP_JPR  = 4'd7,
        OP_BRH  = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_EQ = 3'd1,
        COND_NE = 3'd2,
        COND_LT = 3'd3,
        COND_GE = 3'd4,
        COND_CS = 3'd5,
        COND_CC = 3'd6,
        COND_NV = 3'd7
    } brh_cond_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_t;

endpackage

// File: rtl/brh_cond_eval.sv
// Branch condition evaluator: maps a 3-bit condition code and the ALU flags to taken.
module brh_cond_eval
    import defs_pkg::*;
(
    input  alu_flags_t flags,
    input  brh_cond_t  cond,
    output logic       taken
);

    logic lt;
    assign lt = flags.negative ^ flags.overflow;

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flags.zero;
            COND_NE: taken = ~flags.zero;
            COND_LT: taken = lt;
            COND_GE: taken = ~lt;
            COND_CS: taken = flags.carry;
            COND_CC: taken = ~flags.carry;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle CPU control FSM with ROM/memory wait states, bus timeout,
// conditional branches, illegal-opcode trap and instruction-boundary stall.
module ctrl_fsm
    import defs_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] ir,
    input  alu_flags_t         flags,
    input  logic               rom_ready,
    input  logic               mem_ready,
    input  logic               stall,
    output ctrl_sig_t          ctrl,
    output alu_opcode_t        alu_op,
    output ctrl_state_t        state_o,
    output logic               branch_taken,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    localparam logic [TMO_W-1:0] TMO_LAST =
        (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t      state_q, state_d;
    trap_cause_t      cause_q, cause_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    opcode_t   opcode;
    brh_cond_t cond;
    logic      brh_taken;
    logic      waiting;
    logic      tmo_hit;
    logic      ir_unused;

    assign opcode    = opcode_t'(ir[INSTR_W-1 -: 4]);
    assign cond      = brh_cond_t'(ir[INSTR_W-5 -: 3]);
    assign ir_unused = ^ir[INSTR_W-8:3];

    brh_cond_eval u_brh_cond_eval (
        .flags (flags),
        .cond  (cond),
        .taken (brh_taken)
    );

    // A bus request is outstanding and its ready has not arrived this cycle.
    always_comb begin
        waiting = 1'b0;
        unique case (state_q)
            STATE_FETCH:                 waiting = ~stall & ~rom_ready;
            STATE_MEM_LW, STATE_MEM_SW:  waiting = ~mem_ready;
            default:                     waiting = 1'b0;
        endcase
    end

    assign tmo_hit = (MEM_TIMEOUT != 0) && waiting && (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_FETCH;
            cause_q <= TRAP_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            STATE_FETCH: begin
                if (!stall) begin
                    if (rom_ready) begin
                        state_d = STATE_DECODE;
                    end else if (tmo_hit) begin
                        state_d = STATE_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
            end
            STATE_DECODE: begin
                unique case (opcode)
                    OP_LI:   state_d = STATE_WB_LI;
                    OP_ADDI: state_d = STATE_EXEC_ADDI;
                    OP_LW:   state_d = STATE_EXEC_LW;
                    OP_SW:   state_d = STATE_EXEC_SW;
                    OP_ALU:  state_d = STATE_EXEC_ALU;
                    OP_LINK: state_d = STATE_EXEC_LINK;
                    OP_JMP:  state_d = STATE_EXEC_JMP;
                    OP_JPR:  state_d = STATE_EXEC_JPR;
                    OP_BRH:  state_d = STATE_EXEC_BRH;
                    default: begin
                        state_d = STATE_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            STATE_EXEC_ADDI: state_d = STATE_WB_ADDI;
            STATE_EXEC_LW:   state_d = STATE_MEM_LW;
            STATE_EXEC_SW:   state_d = STATE_MEM_SW;
            STATE_EXEC_ALU:  state_d = STATE_WB_ALU;
            STATE_EXEC_LINK: state_d = STATE_EXEC_JMP;
            STATE_MEM_LW, STATE_MEM_SW: begin
                if (mem_ready) begin
                    state_d = (state_q == STATE_MEM_LW) ? STATE_WB_LW : STATE_FETCH;
                end else if (tmo_hit) begin
                    state_d = STATE_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            STATE_TRAP:      state_d = STATE_TRAP;
            default:         state_d = STATE_FETCH;
        endcase

        // Any state change starts a fresh wait count; saturate so a disabled timeout cannot wrap.
        if (state_d != state_q)
            cnt_d = '0;
        else if (waiting && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_comb begin
        ctrl         = '0;
        alu_op       = ALU_ADD;
        branch_taken = 1'b0;
        state_o      = STATE_FETCH;
        trap         = 1'b0;
        trap_cause   = 2'd0;
        if (rst_n) begin
            state_o    = state_q;
            trap       = (state_q == STATE_TRAP);
            trap_cause = cause_q;
            unique case (state_q)
                STATE_FETCH: begin
                    if (!stall) begin
                        ctrl.ROM_read = 1'b1;
                        ctrl.IR_load  = rom_ready;
                        ctrl.PC_write = rom_ready;
                    end
                end
                STATE_DECODE: ctrl.AB_load = 1'b1;
                STATE_EXEC_ADDI: begin
                    ctrl.ALU_op   = 1'b1;
                    ctrl.ACC_load = 1'b1;
                end
                STATE_EXEC_LW: begin
                    ctrl.ALU_op   = 1'b1;
                    ctrl.MAR_load = 1'b1;
                end
                STATE_MEM_LW: begin
                    ctrl.MEM_read = 1'b1;
                    ctrl.MDR_load = mem_ready;
                end
                STATE_EXEC_SW: begin
                    ctrl.ALU_op   = 1'b1;
                    ctrl.MAR_load = 1'b1;
                    ctrl.MDR_load = 1'b1;
                end
                STATE_MEM_SW: ctrl.MEM_write = 1'b1;
                STATE_EXEC_ALU: begin
                    ctrl.ALU_op    = 1'b1;
                    ctrl.ACC_load  = 1'b1;
                    ctrl.FLAG_load = 1'b1;
                    alu_op         = alu_opcode_t'(ir[2:0]);
                end
                STATE_WB_LI, STATE_WB_ADDI, STATE_WB_LW,
                STATE_WB_ALU, STATE_EXEC_LINK: ctrl.RF_write = 1'b1;
                STATE_EXEC_JMP, STATE_EXEC_JPR: ctrl.PC_write = 1'b1;
                STATE_EXEC_BRH: begin
                    ctrl.PC_write = brh_taken;
                    branch_taken  = brh_taken;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_ctrl_fsm;
    import defs_pkg::*;

    localparam logic [11:0] B_ROM = 12'h800, B_IRL = 12'h400, B_PCW = 12'h200, B_ABL = 12'h100;
    localparam logic [11:0] B_ALU = 12'h080, B_ACC = 12'h040, B_FLG = 12'h020, B_MAR = 12'h010;
    localparam logic [11:0] B_MDR = 12'h008, B_MRD = 12'h004, B_MWR = 12'h002, B_RFW = 12'h001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    alu_flags_t  flags;
    logic        rom_ready, mem_ready, stall;
    ctrl_sig_t   ctrl;
    alu_opcode_t alu_op;
    ctrl_state_t state_o;
    logic        branch_taken, trap;
    logic [1:0]  trap_cause;

    typedef struct {
        string       nm;
        logic [23:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ctrl_fsm #(.INSTR_W(16), .MEM_TIMEOUT(4), .TMO_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir           (ir),
        .flags        (flags),
        .rom_ready    (rom_ready),
        .mem_ready    (mem_ready),
        .stall        (stall),
        .ctrl         (ctrl),
        .alu_op       (alu_op),
        .state_o      (state_o),
        .branch_taken (branch_taken),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic chk(input string nm, input ctrl_state_t st, input logic [11:0] c,
                       input alu_opcode_t op = ALU_ADD, input logic bt = 1'b0,
                       input logic tr = 1'b0, input logic [1:0] cause = 2'd0);
        exp_t e;
        e.nm = nm;
        e.v  = {st, c, op, bt, tr, cause};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t        e;
            logic [23:0] act;
            e   = sb.pop_front();
            act = {state_o, ctrl, alu_op, branch_taken, trap, trap_cause};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got state=%0d ctrl=%h op=%0d bt=%b trap=%b cause=%0d, exp state=%0d ctrl=%h op=%0d bt=%b trap=%b cause=%0d",
                         e.nm, act[23:19], act[18:7], act[6:4], act[3], act[2], act[1:0],
                         e.v[23:19], e.v[18:7], e.v[6:4], e.v[3], e.v[2], e.v[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ir = '0; flags = '0; rom_ready = 1'b1; mem_ready = 1'b1; stall = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) chk("reset_hold", STATE_FETCH, 12'h000);

        // LI
        rst_n = 1'b1; ir = 16'h0000;
        chk("li_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("li_decode", STATE_DECODE, B_ABL);
        chk("li_wb", STATE_WB_LI, B_RFW);

        // LW with three wait cycles; ready on the last allowed count wins
        ir = 16'h2000;
        chk("lw_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("lw_decode", STATE_DECODE, B_ABL);
        chk("lw_exec", STATE_EXEC_LW, B_ALU | B_MAR);
        mem_ready = 1'b0;
        repeat (3) chk("lw_wait", STATE_MEM_LW, B_MRD);
        mem_ready = 1'b1;
        chk("lw_ready", STATE_MEM_LW, B_MRD | B_MDR);
        chk("lw_wb", STATE_WB_LW, B_RFW);

        ir = 16'h1000;
        chk("addi_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("addi_decode", STATE_DECODE, B_ABL);
        chk("addi_exec", STATE_EXEC_ADDI, B_ALU | B_ACC);
        chk("addi_wb", STATE_WB_ADDI, B_RFW);

        ir = 16'h5000;
        chk("link_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("link_decode", STATE_DECODE, B_ABL);
        chk("link_exec", STATE_EXEC_LINK, B_RFW);
        chk("link_jmp", STATE_EXEC_JMP, B_PCW);

        ir = 16'h7000;
        chk("jpr_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("jpr_decode", STATE_DECODE, B_ABL);
        chk("jpr_exec", STATE_EXEC_JPR, B_PCW);

        // Branches: EQ taken / not taken, LT taken, NV never
        ir = 16'h8200; flags = '0; flags.zero = 1'b1;
        chk("beq_t_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("beq_t_decode", STATE_DECODE, B_ABL);
        chk("beq_taken", STATE_EXEC_BRH, B_PCW, ALU_ADD, 1'b1);
        flags.zero = 1'b0;
        chk("beq_n_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("beq_n_decode", STATE_DECODE, B_ABL);
        chk("beq_not", STATE_EXEC_BRH, 12'h000);
        ir = 16'h8600; flags.negative = 1'b1;
        chk("blt_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("blt_decode", STATE_DECODE, B_ABL);
        chk("blt_taken", STATE_EXEC_BRH, B_PCW, ALU_ADD, 1'b1);
        ir = 16'h8E00; flags = '0; flags.zero = 1'b1;
        chk("bnv_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("bnv_decode", STATE_DECODE, B_ABL);
        chk("bnv_not", STATE_EXEC_BRH, 12'h000);

        // Stall at the boundary, then ALU with a mid-instruction stall that must be ignored
        stall = 1'b1;
        repeat (5) chk("stall_hold", STATE_FETCH, 12'h000);
        stall = 1'b0; ir = 16'h4007;
        chk("alu_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("alu_decode", STATE_DECODE, B_ABL);
        stall = 1'b1;
        chk("alu_exec", STATE_EXEC_ALU, B_ALU | B_ACC | B_FLG, ALU_SRA);
        stall = 1'b0;
        chk("alu_wb", STATE_WB_ALU, B_RFW);

        // Reset during a memory wait, then a ROM timeout
        ir = 16'h2000;
        chk("lw2_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("lw2_decode", STATE_DECODE, B_ABL);
        chk("lw2_exec", STATE_EXEC_LW, B_ALU | B_MAR);
        mem_ready = 1'b0;
        chk("lw2_wait", STATE_MEM_LW, B_MRD);
        rst_n = 1'b0;
        chk("rst_in_mem", STATE_FETCH, 12'h000);
        rst_n = 1'b1; rom_ready = 1'b0;
        repeat (4) chk("rom_wait", STATE_FETCH, B_ROM);
        chk("rom_tmo_trap", STATE_TRAP, 12'h000, ALU_ADD, 1'b0, 1'b1, 2'd2);
        rst_n = 1'b0;
        chk("rst_after_rom_tmo", STATE_FETCH, 12'h000);

        // SW with mem_ready stuck low: four wait cycles then timeout trap
        rst_n = 1'b1; rom_ready = 1'b1; ir = 16'h3000;
        chk("sw_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("sw_decode", STATE_DECODE, B_ABL);
        chk("sw_exec", STATE_EXEC_SW, B_ALU | B_MAR | B_MDR);
        repeat (4) chk("sw_wait", STATE_MEM_SW, B_MWR);
        mem_ready = 1'b1;
        repeat (2) chk("sw_tmo_trap", STATE_TRAP, 12'h000, ALU_ADD, 1'b0, 1'b1, 2'd2);
        rst_n = 1'b0;
        chk("rst_after_sw_tmo", STATE_FETCH, 12'h000);

        // Illegal opcode: trap is absorbing with ctrl held at zero
        rst_n = 1'b1; ir = 16'hF000;
        chk("ill_fetch", STATE_FETCH, B_ROM | B_IRL | B_PCW);
        chk("ill_decode", STATE_DECODE, B_ABL);
        repeat (10) chk("ill_trap", STATE_TRAP, 12'h000, ALU_ADD, 1'b0, 1'b1, 2'd1);
        rst_n = 1'b0;
        chk("rst_final", STATE_FETCH, 12'h000);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
